// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Write-back stage holding up to two entries in a skid buffer
//               (head register drives out_*, skid register absorbs one extra
//               entry). in_ready depends only on registered occupancy.
//               Optional macro WB_STAGE_FORWARD_EN adds fwd_* outputs that
//               present the youngest held entry with we=1.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int DATA_W = 18,
    parameter int RD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_we,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_we
`ifdef WB_STAGE_FORWARD_EN
    ,
    output logic              fwd_valid,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [DATA_W-1:0]   head_data_q, head_data_d;
    logic [RD_W-1:0]     head_rd_q,   head_rd_d;
    logic                head_we_q,   head_we_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [RD_W-1:0]     skid_rd_q,   skid_rd_d;
    logic                skid_we_q,   skid_we_d;

    logic                w_push;
    logic                w_pop;

    // Handshake flags come straight from registered state, so in_ready has
    // no path from out_ready.
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_data_q;
    assign out_rd    = head_rd_q;
    assign out_we    = head_we_q;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Next-state and data movement; flush wins over any same-cycle transfer.
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_rd_d   = head_rd_q;
        head_we_d   = head_we_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;
        skid_we_d   = skid_we_q;

        if (flush) begin
            state_d     = ST_EMPTY;
            head_data_d = '0;
            head_rd_d   = '0;
            head_we_d   = 1'b0;
            skid_data_d = '0;
            skid_rd_d   = '0;
            skid_we_d   = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_push) begin
                        head_data_d = in_data;
                        head_rd_d   = in_rd;
                        head_we_d   = in_we;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        // Head leaves and the new entry replaces it directly.
                        head_data_d = in_data;
                        head_rd_d   = in_rd;
                        head_we_d   = in_we;
                    end else if (w_push) begin
                        skid_data_d = in_data;
                        skid_rd_d   = in_rd;
                        skid_we_d   = in_we;
                        state_d     = ST_TWO;
                    end else if (w_pop) begin
                        state_d     = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        head_data_d = skid_data_q;
                        head_rd_d   = skid_rd_q;
                        head_we_d   = skid_we_q;
                        state_d     = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            head_data_q <= '0;
            head_rd_q   <= '0;
            head_we_q   <= 1'b0;
            skid_data_q <= '0;
            skid_rd_q   <= '0;
            skid_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_rd_q   <= head_rd_d;
            head_we_q   <= head_we_d;
            skid_data_q <= skid_data_d;
            skid_rd_q   <= skid_rd_d;
            skid_we_q   <= skid_we_d;
        end
    end

`ifdef WB_STAGE_FORWARD_EN
    // Forward the youngest writing entry: skid is younger than head.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_rd    = '0;
        fwd_data  = '0;
        if ((state_q == ST_TWO) && skid_we_q) begin
            fwd_valid = 1'b1;
            fwd_rd    = skid_rd_q;
            fwd_data  = skid_data_q;
        end else if ((state_q != ST_EMPTY) && head_we_q) begin
            fwd_valid = 1'b1;
            fwd_rd    = head_rd_q;
            fwd_data  = head_data_q;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage: directed scenarios plus a
//               randomized run compared against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    localparam int DATA_W = 18;
    localparam int RD_W   = 4;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [RD_W-1:0]   rd;
        logic              we;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [RD_W-1:0]   in_rd;
    logic              in_we;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_we;
`ifdef WB_STAGE_FORWARD_EN
    logic              fwd_valid;
    logic [RD_W-1:0]   fwd_rd;
    logic [DATA_W-1:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rd     (in_rd),
        .in_we     (in_we),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_we    (out_we)
`ifdef WB_STAGE_FORWARD_EN
        ,
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        in_rd     = '0;
        in_we     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [DATA_W-1:0] d, input logic [RD_W-1:0] rd,
                            input logic we);
        in_valid = 1'b1;
        in_data  = d;
        in_rd    = rd;
        in_we    = we;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (out_rd !== '0 || out_we !== 1'b0) begin errors++; $display("FAIL reset_rd_we: got rd=%h we=%b want 0/0", out_rd, out_we); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef WB_STAGE_FORWARD_EN
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid: got %b want 0", fwd_valid); end
`endif
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        push_one(18'h2ABCD, 4'd5, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 18'h2ABCD) begin errors++; $display("FAIL basic_data: got %h want 2abcd", out_data); end
        checks++; if (out_rd !== 4'd5 || out_we !== 1'b1) begin errors++; $display("FAIL basic_rd_we: got rd=%0d we=%b want 5/1", out_rd, out_we); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_fill();
        do_reset();
        out_ready = 1'b0;
        push_one(18'h00011, 4'd1, 1'b1);
        push_one(18'h00022, 4'd2, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        push_one(18'h00033, 4'd3, 1'b1);
        checks++; if (out_data !== 18'h00011) begin errors++; $display("FAIL fill_head_hold: got %h want 00011", out_data); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 18'h00022) begin errors++; $display("FAIL fill_second: got v=%b d=%h want 1/00022", out_valid, out_data); end
        checks++; if (out_we !== 1'b0) begin errors++; $display("FAIL fill_we0_pass: got %b want 0", out_we); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_third_dropped: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        push_one(18'h00055, 4'd6, 1'b1);
        in_valid = 1'b1; in_data = 18'h3FFFF; in_rd = 4'd9; in_we = 1'b1;
        out_ready = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_ready_before: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 18'h3FFFF) begin errors++; $display("FAIL simul_data: got v=%b d=%h want 1/3ffff", out_valid, out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_ready_after: got %b want 1", in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_one_entry: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        push_one(18'h00AAA, 4'd1, 1'b1);
        push_one(18'h00BBB, 4'd2, 1'b1);
        flush = 1'b1; in_valid = 1'b1; in_data = 18'h01234; in_rd = 4'd4; in_we = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL flush_state: got v=%b d=%h want 0/0", out_valid, out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", in_ready); end
`ifdef WB_STAGE_FORWARD_EN
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL flush_fwd: got %b want 0", fwd_valid); end
`endif
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_lost: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_in_two();
        do_reset();
        push_one(18'h00777, 4'd7, 1'b1);
        push_one(18'h00888, 4'd8, 1'b1);
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_rd !== '0 || out_we !== 1'b0) begin
            errors++; $display("FAIL rst_two_outputs: got v=%b d=%h rd=%h we=%b want all 0", out_valid, out_data, out_rd, out_we); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_two_ready: got %b want 1", in_ready); end
    endtask

`ifdef WB_STAGE_FORWARD_EN
    task automatic test_forward();
        do_reset();
        push_one(18'h00100, 4'd3, 1'b1);
        push_one(18'h00200, 4'd3, 1'b1);
        checks++; if (fwd_valid !== 1'b1 || fwd_data !== 18'h00200 || fwd_rd !== 4'd3) begin
            errors++; $display("FAIL fwd_skid: got v=%b d=%h rd=%0d want 1/00200/3", fwd_valid, fwd_data, fwd_rd); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (fwd_data !== 18'h00200) begin errors++; $display("FAIL fwd_after_pop: got %h want 00200", fwd_data); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        push_one(18'h00999, 4'd7, 1'b0);
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL fwd_we0: got %b want 0", fwd_valid); end
    endtask
`endif

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        bit   push, pop, fl;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rand_in_ready cyc %0d: got %b want %b", cyc, in_ready, q.size() < 2); end
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_out_valid cyc %0d: got %b want %b", cyc, out_valid, q.size() > 0); end
            if (q.size() > 0) begin
                checks++; if ({out_data, out_rd, out_we} !== q[0]) begin
                    errors++; $display("FAIL rand_head cyc %0d: got %h/%h/%b want %h/%h/%b", cyc, out_data, out_rd, out_we, q[0].d, q[0].rd, q[0].we); end
            end
`ifdef WB_STAGE_FORWARD_EN
            begin
                bit         fv = 1'b0;
                ent_t       fe = '0;
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (!fv && q[i].we) begin fv = 1'b1; fe = q[i]; end
                end
                checks++; if (fwd_valid !== fv || (fv && (fwd_data !== fe.d || fwd_rd !== fe.rd))) begin
                    errors++; $display("FAIL rand_fwd cyc %0d: got %b/%h/%h want %b/%h/%h", cyc, fwd_valid, fwd_data, fwd_rd, fv, fe.d, fe.rd); end
            end
`endif
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            fl        = ($urandom_range(0, 31) == 0);
            flush     = fl;
            in_data   = DATA_W'($urandom);
            in_rd     = RD_W'($urandom);
            in_we     = ($urandom_range(0, 3) != 0);
            push = in_valid && (q.size() < 2);
            pop  = out_ready && (q.size() > 0);
            e.d = in_data; e.rd = in_rd; e.we = in_we;
            if (fl) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(e);
            end
            step();
            if (fl) begin
                checks++; if (out_data !== '0 || out_we !== 1'b0) begin
                    errors++; $display("FAIL rand_flush_clear cyc %0d: got d=%h we=%b want 0/0", cyc, out_data, out_we); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_fill();
        test_simultaneous();
        test_flush();
        test_reset_in_two();
`ifdef WB_STAGE_FORWARD_EN
        test_forward();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
